// File: rtl/sysmgr_pkg.sv
// -----------------------------------------------------------------------------
// sysmgr_pkg
// Shared definitions for the system-manager reset sequencer:
//   - seq_state_e : sequencer state encoding (2 bits)
//   - DEF_*       : default parameter values used by the sequencer blocks
//   - lowest_set  : index of the lowest set bit of a request vector
// -----------------------------------------------------------------------------
package sysmgr_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int DEF_N_DOM       = 3;
  localparam int DEF_LOCK_STABLE = 16;
  localparam int DEF_HOLD        = 4;
  localparam int DEF_CNT_W       = 8;

  // Up to 8 domains; one extra code (8) means "no bit set".
  localparam int MAX_DOM = 8;
  localparam int STAGE_W = 4;

  // Returns the index of the lowest set bit, or MAX_DOM when v is zero.
  function automatic logic [STAGE_W-1:0] lowest_set(input logic [MAX_DOM-1:0] v);
    logic [STAGE_W-1:0] idx;
    idx = STAGE_W'(MAX_DOM);
    for (int k = MAX_DOM - 1; k >= 0; k--) begin
      if (v[k]) idx = STAGE_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sysmgr_lock_filter.sv
// -----------------------------------------------------------------------------
// sysmgr_lock_filter
// Brings the asynchronous PLL lock into the clk domain and qualifies it.
// Ports:
//   clk     in  block clock
//   rst_n   in  synchronous active-low reset
//   lock    in  asynchronous lock indication
//   lock_s  out synchronised lock (2-FF)
//   lock_ok out high in the cycle where lock_s has been high for LOCK_STABLE
//               consecutive samples (including the current one), and after
// -----------------------------------------------------------------------------
module sysmgr_lock_filter
  import sysmgr_pkg::*;
#(
  parameter int LOCK_STABLE = DEF_LOCK_STABLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock,
  output logic lock_s,
  output logic lock_ok
);

  logic        meta_q;
  logic        sync_q;
  logic [15:0] stable_cnt_q;

  // Synchroniser plus a run-length counter of lock_s high samples. The
  // counter saturates one below the target so lock_ok can be decoded
  // together with the current sample, letting the FSM leave STABLE on the
  // very edge that sees the LOCK_STABLE-th high sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q       <= 1'b0;
      sync_q       <= 1'b0;
      stable_cnt_q <= '0;
    end else begin
      meta_q <= lock;
      sync_q <= meta_q;
      if (!sync_q) begin
        stable_cnt_q <= '0;
      end else if (stable_cnt_q != 16'(LOCK_STABLE - 1)) begin
        stable_cnt_q <= stable_cnt_q + 16'd1;
      end
    end
  end

  assign lock_s  = sync_q;
  assign lock_ok = sync_q && (stable_cnt_q == 16'(LOCK_STABLE - 1));

endmodule

// File: rtl/sysmgr_rst_seq.sv
// -----------------------------------------------------------------------------
// sysmgr_rst_seq
// Lock-gated reset sequencer: waits for a debounced PLL lock, then releases
// N_DOM reset domains in index order with HOLD cycles per stage. Lock loss
// restarts the whole sequence; software requests restart from the lowest
// requested domain.
// Ports:
//   clk           in  block clock
//   rst_n         in  synchronous active-low reset
//   lock          in  asynchronous PLL lock
//   sw_rst_req    in  per-domain software reset request [N_DOM]
//   rst_out       out registered active-high domain resets [N_DOM]
//   ready         out registered, all domains released
//   lock_loss_cnt out saturating lock-loss event count [CNT_W]
// Configuration macro:
//   SYSMGR_LOCK_CNT_EN  defined: lock-loss counter present;
//                       undefined: lock_loss_cnt tied to zero.
// -----------------------------------------------------------------------------
module sysmgr_rst_seq
  import sysmgr_pkg::*;
#(
  parameter int N_DOM       = DEF_N_DOM,
  parameter int LOCK_STABLE = DEF_LOCK_STABLE,
  parameter int HOLD        = DEF_HOLD,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lock,
  input  logic [N_DOM-1:0] sw_rst_req,
  output logic [N_DOM-1:0] rst_out,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  logic                 lock_s;
  logic                 lock_ok;
  seq_state_e           state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [7:0]           hold_q, hold_d;
  logic [N_DOM-1:0]     rst_out_q, rst_out_d;
  logic                 ready_q, ready_d;
  logic [STAGE_W-1:0]   req_idx;

  sysmgr_lock_filter #(
    .LOCK_STABLE(LOCK_STABLE)
  ) u_lock_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .lock   (lock),
    .lock_s (lock_s),
    .lock_ok(lock_ok)
  );

  assign req_idx = lowest_set(MAX_DOM'(sw_rst_req));

  // Next-state and next-output logic. A request restarts at the lowest
  // requested stage and re-asserts every domain from there upward; in
  // RELEASE only requests below the current stage matter because the
  // others are still held. In RUN any request qualifies, since
  // req_idx < N_DOM exactly when some bit is set.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    hold_d    = hold_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    unique case (state_q)
      WAIT_LOCK: begin
        rst_out_d = '1;
        ready_d   = 1'b0;
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (lock_ok) begin
          state_d = RELEASE;
          stage_d = '0;
          hold_d  = '0;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end else if (req_idx < stage_q) begin
          stage_d = req_idx;
          hold_d  = '0;
          for (int k = 0; k < N_DOM; k++) begin
            if (k >= int'(req_idx)) rst_out_d[k] = 1'b1;
          end
        end else if (hold_q == 8'(HOLD - 1)) begin
          hold_d = '0;
          for (int k = 0; k < N_DOM; k++) begin
            if (k == int'(stage_q)) rst_out_d[k] = 1'b0;
          end
          if (stage_q == STAGE_W'(N_DOM - 1)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end else if (req_idx < STAGE_W'(N_DOM)) begin
          state_d = RELEASE;
          stage_d = req_idx;
          hold_d  = '0;
          ready_d = 1'b0;
          for (int k = 0; k < N_DOM; k++) begin
            if (k >= int'(req_idx)) rst_out_d[k] = 1'b1;
          end
        end
      end
      default: begin
        state_d   = WAIT_LOCK;
        rst_out_d = '1;
        ready_d   = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOCK;
      stage_q   <= '0;
      hold_q    <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      hold_q    <= hold_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign rst_out = rst_out_q;
  assign ready   = ready_q;

`ifdef SYSMGR_LOCK_CNT_EN
  logic             loss_evt;
  logic [CNT_W-1:0] loss_cnt_q;

  // Only losses after sequencing has started count; a drop while still
  // debouncing in STABLE is just a noisy lock, not an event.
  assign loss_evt = !lock_s && ((state_q == RELEASE) || (state_q == RUN));

  // Saturating lock-loss counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
    end else if (loss_evt && (loss_cnt_q != {CNT_W{1'b1}})) begin
      loss_cnt_q <= loss_cnt_q + CNT_W'(1);
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_sysmgr_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_sysmgr_rst_seq
// Directed bench for sysmgr_rst_seq with N_DOM=3, LOCK_STABLE=16, HOLD=4 and
// CNT_W=2. Edge 0 is the last clock edge with rst_n low; expected release
// edges are counted from there.
// -----------------------------------------------------------------------------
module tb_sysmgr_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock;
  logic [2:0] sw_rst_req;
  logic [2:0] rst_out;
  logic       ready;
  logic [1:0] lock_loss_cnt;

  int total    = 0;
  int bad      = 0;
  int edge_num = 0;

  sysmgr_rst_seq #(
    .N_DOM      (3),
    .LOCK_STABLE(16),
    .HOLD       (4),
    .CNT_W      (2)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lock         (lock),
    .sw_rst_req   (sw_rst_req),
    .rst_out      (rst_out),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic l, input logic [2:0] sw);
    rst_n      = r;
    lock       = l;
    sw_rst_req = sw;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
    edge_num++;
  endtask

  task automatic runTo(input int target);
    while (edge_num < target) step();
  endtask

  // Expected loss count for n events on a 2-bit saturating counter.
  function automatic logic [1:0] expCnt(input int n);
    logic [1:0] v;
    v = (n > 3) ? 2'd3 : 2'(n);
`ifndef SYSMGR_LOCK_CNT_EN
    v = 2'd0;
`endif
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [2:0] exp_rst,
                             input logic exp_rdy, input logic [1:0] exp_cnt);
    total++;
    assert (rst_out === exp_rst) else begin
      bad++;
      $error("[TB] FAIL %s rst_out @edge %0d: observed=%b expected=%b", tag, edge_num, rst_out, exp_rst);
    end
    total++;
    assert (ready === exp_rdy) else begin
      bad++;
      $error("[TB] FAIL %s ready @edge %0d: observed=%b expected=%b", tag, edge_num, ready, exp_rdy);
    end
    total++;
    assert (lock_loss_cnt === exp_cnt) else begin
      bad++;
      $error("[TB] FAIL %s lock_loss_cnt @edge %0d: observed=%0d expected=%0d", tag, edge_num, lock_loss_cnt, exp_cnt);
    end
  endtask

  initial begin
    int e;
    applyStimulus(1'b0, 1'b0, 3'b000);
    edge_num = -6;

    // Power-up: five reset edges with lock low.
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("powerup", 3'b111, 1'b0, 2'd0);
    end
    // Lock rises before edge 0, which is still a reset edge.
    applyStimulus(1'b0, 1'b1, 3'b000);
    step();
    checkOutput("reset_edge0", 3'b111, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 3'b000);

    // Clean start: stage 0 at 18, releases at 22/26/30.
    runTo(17); checkOutput("clean_stable", 3'b111, 1'b0, 2'd0);
    runTo(21); checkOutput("clean_pre_d0", 3'b111, 1'b0, 2'd0);
    runTo(22); checkOutput("clean_d0",     3'b110, 1'b0, 2'd0);
    runTo(25); checkOutput("clean_pre_d1", 3'b110, 1'b0, 2'd0);
    runTo(26); checkOutput("clean_d1",     3'b100, 1'b0, 2'd0);
    runTo(29); checkOutput("clean_pre_d2", 3'b100, 1'b0, 2'd0);
    runTo(30); checkOutput("clean_ready",  3'b000, 1'b1, 2'd0);

    // Lock loss in RUN: falls before edge 31, outputs reset at edge 33.
    applyStimulus(1'b1, 1'b0, 3'b000);
    runTo(32); checkOutput("loss_pre",  3'b000, 1'b1, 2'd0);
    runTo(33); checkOutput("loss_run",  3'b111, 1'b0, expCnt(1));
    // Lock returns before edge 36: stage 0 at 53, releases 57/61/65.
    runTo(35);
    applyStimulus(1'b1, 1'b1, 3'b000);
    runTo(56); checkOutput("reseq_pre_d0", 3'b111, 1'b0, expCnt(1));
    runTo(57); checkOutput("reseq_d0",     3'b110, 1'b0, expCnt(1));
    runTo(61); checkOutput("reseq_d1",     3'b100, 1'b0, expCnt(1));
    runTo(65); checkOutput("reseq_ready",  3'b000, 1'b1, expCnt(1));

    // Software request 3'b010 in RUN.
    applyStimulus(1'b1, 1'b1, 3'b010);
    runTo(66);
    applyStimulus(1'b1, 1'b1, 3'b000);
    checkOutput("sw_assert",  3'b110, 1'b0, expCnt(1));
    runTo(69); checkOutput("sw_pre_d1", 3'b110, 1'b0, expCnt(1));
    runTo(70); checkOutput("sw_d1",     3'b100, 1'b0, expCnt(1));
    // Request 3'b001 at stage 2 restarts from stage 0.
    runTo(71);
    applyStimulus(1'b1, 1'b1, 3'b001);
    runTo(72);
    applyStimulus(1'b1, 1'b1, 3'b000);
    checkOutput("sw_restart0", 3'b111, 1'b0, expCnt(1));
    runTo(75); checkOutput("sw_pre_d0", 3'b111, 1'b0, expCnt(1));
    runTo(76); checkOutput("sw_d0",     3'b110, 1'b0, expCnt(1));
    // Request for domain 2 while at stage 1 is ignored.
    runTo(77);
    applyStimulus(1'b1, 1'b1, 3'b100);
    runTo(78);
    applyStimulus(1'b1, 1'b1, 3'b000);
    checkOutput("sw_ignored",   3'b110, 1'b0, expCnt(1));
    runTo(79); checkOutput("sw_ign_pre", 3'b110, 1'b0, expCnt(1));
    runTo(80); checkOutput("sw_ign_d1",  3'b100, 1'b0, expCnt(1));
    runTo(84); checkOutput("sw_ready",   3'b000, 1'b1, expCnt(1));

    // Second loss, then a glitchy lock: high 10 cycles, low 1, high.
    applyStimulus(1'b1, 1'b0, 3'b000);
    runTo(86); checkOutput("loss2_pre", 3'b000, 1'b1, expCnt(1));
    runTo(87); checkOutput("loss2",     3'b111, 1'b0, expCnt(2));
    runTo(89);
    applyStimulus(1'b1, 1'b1, 3'b000);
    runTo(99);
    applyStimulus(1'b1, 1'b0, 3'b000);
    runTo(100);
    applyStimulus(1'b1, 1'b1, 3'b000);
    runTo(111); checkOutput("glitch_no_early", 3'b111, 1'b0, expCnt(2));
    runTo(121); checkOutput("glitch_pre_d0",   3'b111, 1'b0, expCnt(2));
    runTo(122); checkOutput("glitch_d0",       3'b110, 1'b0, expCnt(2));

    // rst_n low during stage 1.
    runTo(123);
    applyStimulus(1'b0, 1'b1, 3'b000);
    runTo(124);
    checkOutput("rstn_mid", 3'b111, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 3'b000);
    runTo(145); checkOutput("rstn_pre_d0", 3'b111, 1'b0, 2'd0);
    runTo(146); checkOutput("rstn_d0",     3'b110, 1'b0, 2'd0);
    runTo(154); checkOutput("rstn_ready",  3'b000, 1'b1, 2'd0);

    // Five losses from RUN: counter saturates at 3.
    for (int k = 1; k <= 5; k++) begin
      e = edge_num;
      applyStimulus(1'b1, 1'b0, 3'b000);
      runTo(e + 3);
      checkOutput("sat_loss", 3'b111, 1'b0, expCnt(k));
      applyStimulus(1'b1, 1'b1, 3'b000);
      runTo(e + 33);
      checkOutput("sat_run", 3'b000, 1'b1, expCnt(k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
